// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: fetch FSM states, reset PC, instruction width, NOP.
// Also holds the fetch-address legality check used by the PC logic.
package rv32i_pkg;

   localparam int                 INSTR_W          = 32;
   localparam logic [31:0]        RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_FAULT  = 2'd2
   } fetch_state_t;

   // 33-bit sum so an address near 2^32 cannot wrap past the range check.
   function automatic logic fetch_addr_ok(input logic [31:0] addr, input int unsigned mem_bytes);
      logic [32:0] w_last;
      w_last = {1'b0, addr} + 33'd3;
      return (addr[1:0] == 2'b00) && (w_last < 33'(mem_bytes));
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush clears valid only, load captures pc/instr/pc+4, otherwise hold.
// One-cycle latency; flush wins over load.
module ifid_reg
   import rv32i_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic               i_flush,
   input  logic [31:0]        i_pc,
   input  logic [INSTR_W-1:0] i_instr,
   output logic               o_valid,
   output logic [31:0]        o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [31:0]        o_pc_plus4
);

   logic               r_valid;
   logic [31:0]        r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic [31:0]        r_pc_plus4;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_pc       <= 32'h0;
         r_instr    <= '0;
         r_pc_plus4 <= 32'h0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid    <= 1'b1;
         r_pc       <= i_pc;
         r_instr    <= i_instr;
         r_pc_plus4 <= i_pc + 32'd4;
      end
   end

   assign o_valid    = r_valid;
   assign o_pc       = r_pc;
   assign o_instr    = r_instr;
   assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: registered PC with redirect > stall > sequential priority, feeding ifid_reg.
// Illegal next PC (misaligned or past IMEM_BYTES) parks the FSM in FAULT until reset.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          IMEM_BYTES = 256
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_target,
   input  logic [INSTR_W-1:0] instruction,
   output logic [31:0]        pc,
   output logic               ifid_valid,
   output logic [31:0]        ifid_pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [31:0]        ifid_pc_plus4,
   output logic               fault
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  w_seq_pc;
   logic         w_load;
   logic         w_flush;

   assign w_seq_pc = r_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_WARMUP;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // A sequential fault still loads the current, legal word; FAULT flushes it next cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
      w_flush     = 1'b0;
      unique case (r_state)
         ST_WARMUP: w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (redirect_valid) begin
               w_flush = 1'b1;
               if (fetch_addr_ok(redirect_target, IMEM_BYTES)) w_pc_nxt = redirect_target;
               else                                            w_state_nxt = ST_FAULT;
            end else if (!stall) begin
               w_load = 1'b1;
               if (fetch_addr_ok(w_seq_pc, IMEM_BYTES)) w_pc_nxt = w_seq_pc;
               else                                     w_state_nxt = ST_FAULT;
            end
         end
         ST_FAULT: w_flush = 1'b1;
         default:  w_state_nxt = ST_FAULT;
      endcase
   end

   ifid_reg u_ifid (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_flush    (w_flush),
      .i_pc       (r_pc),
      .i_instr    (instruction),
      .o_valid    (ifid_valid),
      .o_pc       (ifid_pc),
      .o_instr    (ifid_instr),
      .o_pc_plus4 (ifid_pc_plus4)
   );

   assign pc    = r_pc;
   assign fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model and an IF/ID scoreboard.
module tb_fetch_unit;
   import rv32i_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        fault;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;
   exp_t sb[$];

   logic [31:0] mem [64];

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(256)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .instruction     (instruction),
      .pc              (pc),
      .ifid_valid      (ifid_valid),
      .ifid_pc         (ifid_pc),
      .ifid_instr      (ifid_instr),
      .ifid_pc_plus4   (ifid_pc_plus4),
      .fault           (fault)
   );

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a < 32'd256) return mem[a[7:2]];
      return NOP_INSTR;
   endfunction

   assign instruction = imem(pc);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one unstalled RUN cycle fetching address a; the IF/ID result is scoreboarded.
   task automatic load_step(input logic [31:0] a);
      exp_t e;
      e.pc    = a;
      e.instr = imem(a);
      e.pc4   = a + 32'd4;
      sb.push_back(e);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      cyc();
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("ld_valid", {31'b0, ifid_valid}, 32'd1);
         chk("ld_pc",    ifid_pc,       e.pc);
         chk("ld_instr", ifid_instr,    e.instr);
         chk("ld_pc4",   ifid_pc_plus4, e.pc4);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + (i * 32'h0001_0101);
      mem[6] = 32'h0002_1025;

      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      cyc(); cyc();
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_ifid_pc", ifid_pc, 32'h0);
      chk("rst_ifid_instr", ifid_instr, 32'h0);
      chk("rst_ifid_pc4", ifid_pc_plus4, 32'h0);

      // Warmup cycle, then back-to-back fetch of 0, 4, 8
      reset = 1'b0;
      cyc();
      chk("warm_valid", {31'b0, ifid_valid}, 32'd0);
      chk("warm_pc", pc, 32'h0);
      load_step(32'd0);
      load_step(32'd4);
      load_step(32'd8);
      chk("seq_pc", pc, 32'd12);

      // Redirect back to 8 with an unstalled pipe: one bubble, old IF/ID contents held
      redirect_valid = 1'b1; redirect_target = 32'd8;
      cyc();
      redirect_valid = 1'b0;
      chk("rd8_valid", {31'b0, ifid_valid}, 32'd0);
      chk("rd8_pc", pc, 32'd8);
      chk("rd8_hold_pc", ifid_pc, 32'd8);

      // Stall 3 cycles at pc=8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_pc", pc, 32'd8);
         chk("stall_valid", {31'b0, ifid_valid}, 32'd0);
         chk("stall_ifid_pc", ifid_pc, 32'd8);
         chk("stall_ifid_instr", ifid_instr, mem[2]);
      end
      load_step(32'd8);
      chk("post_stall_pc", pc, 32'd12);

      // Redirect beats stall
      stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd24;
      cyc();
      chk("rd24_valid", {31'b0, ifid_valid}, 32'd0);
      chk("rd24_pc", pc, 32'd24);
      load_step(32'd24);
      chk("rd24_instr_const", ifid_instr, 32'h0002_1025);
      chk("rd24_next_pc", pc, 32'd28);

      // Misaligned redirect -> sticky fault, stall ignored
      redirect_valid = 1'b1; redirect_target = 32'h1A;
      cyc();
      redirect_valid = 1'b0;
      chk("mis_fault", {31'b0, fault}, 32'd1);
      chk("mis_pc", pc, 32'd28);
      chk("mis_valid", {31'b0, ifid_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         stall = ~stall;
         cyc();
         chk("flt_fault", {31'b0, fault}, 32'd1);
         chk("flt_pc", pc, 32'd28);
         chk("flt_valid", {31'b0, ifid_valid}, 32'd0);
      end
      stall = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("clr_fault", {31'b0, fault}, 32'd0);
      chk("clr_pc", pc, 32'h0);
      cyc();

      // Sequential walk to the top of memory
      redirect_valid = 1'b1; redirect_target = 32'd240;
      cyc();
      chk("rd240_pc", pc, 32'd240);
      chk("rd240_fault", {31'b0, fault}, 32'd0);
      load_step(32'd240);
      load_step(32'd244);
      load_step(32'd248);
      chk("top_pc", pc, 32'd252);
      load_step(32'd252);
      chk("top_fault", {31'b0, fault}, 32'd1);
      chk("top_pc_held", pc, 32'd252);
      cyc();
      chk("top_flush_valid", {31'b0, ifid_valid}, 32'd0);
      chk("top_pc_held2", pc, 32'd252);
      chk("top_fault2", {31'b0, fault}, 32'd1);

      // Aligned but out-of-range redirect
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      redirect_valid = 1'b1; redirect_target = 32'd256;
      cyc();
      redirect_valid = 1'b0;
      chk("oor_fault", {31'b0, fault}, 32'd1);
      chk("oor_pc", pc, 32'h0);

      // Wrap-around target must also fault
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      cyc();
      redirect_valid = 1'b0;
      chk("wrap_fault", {31'b0, fault}, 32'd1);
      chk("wrap_pc", pc, 32'h0);

      // Reset while a redirect is presented
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      load_step(32'd0);
      redirect_valid = 1'b1; redirect_target = 32'd40; reset = 1'b1;
      cyc();
      chk("rstrd_pc", pc, 32'h0);
      chk("rstrd_valid", {31'b0, ifid_valid}, 32'd0);
      chk("rstrd_fault", {31'b0, fault}, 32'd0);
      reset = 1'b0; redirect_valid = 1'b0;
      cyc();
      chk("rstrd_warm_pc", pc, 32'h0);
      chk("rstrd_warm_valid", {31'b0, ifid_valid}, 32'd0);
      load_step(32'd0);
      chk("rstrd_run_pc", pc, 32'd4);

      chk("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
